sparse_dot_unit: RTL
====================

SPARSE_DOT_UNIT -- requirements
Module: sparse_dot_unit

Interface
REQ-001 SHALL have parameter MATRIX_N, default 4, meaning the maximum entries per row/col packet.
REQ-002 SHALL have parameter HEADER, default 1, meaning the header size in bytes.
REQ-003 SHALL have parameter ACC_W, default 40, meaning the accumulator/result width; ACC_W >= 32 + clog2(MATRIX_N) + 1.
REQ-004 SHALL define DATA_WIDTH = HEADER*8 + 32*MATRIX_N.
REQ-005 clk  input  1  sole clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  DATA_WIDTH  packet from comm_controller rx_data.
REQ-008 in_valid  input  1  one-cycle pulse (comm_controller rx_complete); in_data valid this cycle.
REQ-009 in_sel  input  1  0 = packet is a matrix row, 1 = packet is a matrix column.
REQ-010 in_ready  output  1  high when a packet will be accepted.
REQ-011 result  output  ACC_W  signed dot product of the loaded row and column.
REQ-012 result_valid  output  1  result is valid; held until acknowledged.
REQ-013 result_ack  input  1  consumer accepts result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Packet format: count = in_data[DATA_WIDTH-1 -: 8*HEADER]; V = in_data[32*MATRIX_N-1 : 16*MATRIX_N]; I = in_data[16*MATRIX_N-1 : 0].
REQ-016 Entries are right-aligned: entry k (k=0 first received, 0<=k<count) value = V[16*(count-1-k) +: 16], index = I[16*(count-1-k) +: 16].
REQ-017 Values are 16-bit two's complement; indices are ascending unsigned.
REQ-018 count > MATRIX_N SHALL be clamped to MATRIX_N; count = 0 SHALL be an empty vector.
REQ-019 States: IDLE, MERGE, DONE.
REQ-020 IDLE: in_ready=1; on in_valid, latch the packet into the row (in_sel=0) or column (in_sel=1) register and set that loaded flag; a repeat load of the same sel overwrites it.
REQ-021 IDLE -> MERGE on the cycle after both loaded flags are set; clear accumulator and pointers i=j=0 on entry.
REQ-022 IDLE -> DONE directly, with result=0, when both are loaded and either count is 0.
REQ-023 MERGE, one comparison per cycle: idx_r[i]==idx_c[j] -> acc += val_r[i]*val_c[j] (signed, sign-extended to ACC_W), i++, j++; idx_r[i]<idx_c[j] -> i++; else j++.
REQ-024 MERGE -> DONE when the updated i==row_count or j==col_count; result <= final acc in the same cycle.
REQ-025 Accumulation SHALL wrap modulo 2^ACC_W; no saturation.
REQ-026 MERGE latency SHALL be at most row_count+col_count-1 cycles; result_valid rises the cycle after the final comparison.
REQ-027 DONE: result_valid=1 and result stable until result_ack=1; then -> IDLE, clear result_valid and both loaded flags; result keeps its value.
REQ-028 result_ack outside DONE SHALL be ignored.
REQ-029 in_ready=0 in MERGE and DONE; in_valid in those states SHALL be dropped with no state change.
REQ-030 in_valid in the same cycle as the DONE->IDLE transition SHALL be dropped.

Reset
REQ-031 reset SHALL take priority over all inputs, at the next posedge clk.
REQ-032 On reset: state=IDLE, result=0, result_valid=0, in_ready=1, busy=0, loaded flags cleared, accumulator and pointers=0.
REQ-033 Reset during MERGE or DONE SHALL abandon the operation; no result_valid follows.

Verification
REQ-034 N=4: row count 3, idx {0,1,3}, val {2,3,4}; col count 2, idx {1,3}, val {5,-1} -> result=11 with result_valid; MERGE cycles <= 4.
REQ-035 Disjoint indices: row idx {0,2} val {7,7}, col idx {1,3} val {9,9} -> result=0.
REQ-036 Row count 0, col count 2 -> DONE without MERGE; result=0, result_valid on the cycle after the second load.
REQ-037 Full overlap: count 4 both, idx {0,1,2,3}, all values -32768 -> result = 4*2^30 = 0x1_0000_0000, exact in ACC_W=40.
REQ-038 in_valid during MERGE with a new row -> ignored; result matches the original row; result_ack held low 10 cycles -> result_valid and result stay stable.
REQ-039 Assert reset mid-MERGE -> next cycle IDLE, in_ready=1, result=0; a fresh row+col pair then computes correctly.

Source files
------------

// File: rtl/sparse_dot_unit.sv
// sparse_dot_unit: signed dot product of one sparse row and one sparse column, found by merging their sorted index lists
module sparse_dot_unit #(
  parameter int MATRIX_N = 4,
  parameter int HEADER = 1,
  parameter int ACC_W = 40,
  localparam int DATA_WIDTH = HEADER*8 + 32*MATRIX_N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sel,
  output logic                  in_ready,
  output logic [ACC_W-1:0]      result,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  busy
);
  localparam int CW = $clog2(MATRIX_N + 1);
  localparam int HW = 8*HEADER;
  localparam int EW = 16*MATRIX_N;
  typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;
  state_t state, state_next;
  logic row_ld, col_ld;
  logic [CW-1:0] row_cnt, col_cnt, in_cnt, i, j, i_next, j_next;
  logic [EW-1:0] row_v, row_i, col_v, col_i, in_v, in_i;
  logic [HW-1:0] in_raw;
  logic [15:0] vr, vc, ir, ic;
  logic signed [31:0] prod;
  logic [ACC_W-1:0] acc, acc_next;
  logic hit, lt, fin, both, empty;
  function automatic logic [EW-1:0] rev(input logic [EW-1:0] f, input logic [CW-1:0] c);
    int p;
    rev = '0;
    for (int k = 0; k < MATRIX_N; k++) begin
      p = int'(c) - 1 - k;
      if (p >= 0) rev[16*k +: 16] = f[16*p +: 16];
    end
  endfunction
  always_comb begin
    in_raw = in_data[DATA_WIDTH-1 -: HW];
    in_cnt = (in_raw > HW'(MATRIX_N)) ? CW'(MATRIX_N) : CW'(in_raw);
    in_v = rev(in_data[2*EW-1:EW], in_cnt);
    in_i = rev(in_data[EW-1:0], in_cnt);
    vr = row_v[16*int'(i) +: 16];
    ir = row_i[16*int'(i) +: 16];
    vc = col_v[16*int'(j) +: 16];
    ic = col_i[16*int'(j) +: 16];
    hit = ir == ic;
    lt = ir < ic;
    prod = $signed(vr) * $signed(vc);
    acc_next = hit ? acc + {{(ACC_W-32){prod[31]}}, prod} : acc;
    i_next = (hit || lt) ? i + CW'(1) : i;
    j_next = (hit || !lt) ? j + CW'(1) : j;
    fin = (i_next == row_cnt) || (j_next == col_cnt);
    both = row_ld && col_ld;
    empty = (row_cnt == '0) || (col_cnt == '0);
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = state;
    if (state == IDLE) state_next = both ? (empty ? DONE : MERGE) : IDLE;
    if (state == MERGE) state_next = fin ? DONE : MERGE;
    if (state == DONE) state_next = result_ack ? IDLE : DONE;
  end
  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    result_valid = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      row_ld <= 1'b0;
      col_ld <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
      row_v <= '0;
      row_i <= '0;
      col_v <= '0;
      col_i <= '0;
      acc <= '0;
      i <= '0;
      j <= '0;
      result <= '0;
    end else if (state == IDLE) begin
      if (in_valid && !in_sel) begin
        row_ld <= 1'b1;
        row_cnt <= in_cnt;
        row_v <= in_v;
        row_i <= in_i;
      end
      if (in_valid && in_sel) begin
        col_ld <= 1'b1;
        col_cnt <= in_cnt;
        col_v <= in_v;
        col_i <= in_i;
      end
      if (both) begin
        acc <= '0;
        i <= '0;
        j <= '0;
      end
      if (both && empty) result <= '0;
    end else if (state == MERGE) begin
      acc <= acc_next;
      i <= i_next;
      j <= j_next;
      if (fin) result <= acc_next;
    end else if (result_ack) begin
      row_ld <= 1'b0;
      col_ld <= 1'b0;
    end
  end
endmodule
